neuron_operand_loader: RTL and testbench

NEURON_OPERAND_LOADER -- requirements
Module: neuron_operand_loader

---
 rtl/nn_pkg.sv | 23 ++
 rtl/neuron_operand_loader.sv | 161 ++++++++++++++++
 tb/tb_neuron_operand_loader.sv | 270 +++++++++++++++++++++++++++
 3 files changed

// File: rtl/nn_pkg.sv
// nn_pkg -- constants and types shared by the neuron datapath and the
// operand loader that feeds it.
//   NN_N_IN      : activations / weights per neuron frame
//   NN_DW        : operand byte width (signed two's complement)
//   ldr_state_e  : operand loader FSM state encoding
package nn_pkg;

  localparam int NN_N_IN = 8;
  localparam int NN_DW   = 8;

  typedef enum logic [1:0] {
    LOAD_X = 2'd0,
    LOAD_W = 2'd1,
    LOAD_B = 2'd2,
    HOLD   = 2'd3
  } ldr_state_e;

  // Width of an index that counts 0..n-1, never narrower than one bit.
  function automatic int idx_width(input int n);
    return (n > 1) ? $clog2(n) : 1;
  endfunction

endpackage : nn_pkg

// File: rtl/neuron_operand_loader.sv
// neuron_operand_loader -- deserialises a byte stream into the operand set
// of one neuron: x1..xN_IN, w1..wN_IN, bias.  A frame with x_only=1 on its
// last x byte reuses the stored weights and bias, provided they are valid.
// Ports:
//   clk, rst_n        : clock, asynchronous active-low reset
//   in_data/in_valid  : serial operand byte and its qualifier
//   in_ready          : loader accepts a byte this cycle (registered)
//   x_only            : frame reuses weights/bias; sampled with last x byte
//   flush             : synchronous abort of the current frame
//   x_vec/w_vec/bias  : operand outputs, element 1 in the low byte
//   out_valid         : complete operand set presented (HOLD state)
//   out_ready         : downstream has consumed the set
module neuron_operand_loader
  import nn_pkg::*;
#(
  parameter int N_IN = NN_N_IN,
  parameter int DW   = NN_DW
) (
  input  logic               clk,
  input  logic               rst_n,
  input  logic [DW-1:0]      in_data,
  input  logic               in_valid,
  output logic               in_ready,
  input  logic               x_only,
  input  logic               flush,
  output logic [N_IN*DW-1:0] x_vec,
  output logic [N_IN*DW-1:0] w_vec,
  output logic [DW-1:0]      bias,
  output logic               out_valid,
  input  logic               out_ready
);

  localparam int              IDX_W    = idx_width(N_IN);
  localparam logic [IDX_W-1:0] IDX_LAST = IDX_W'(N_IN - 1);
  localparam logic [IDX_W-1:0] IDX_ZERO = IDX_W'(0);
  localparam logic [IDX_W-1:0] IDX_ONE  = IDX_W'(1);

  ldr_state_e          state_r;
  ldr_state_e          state_n_s;
  logic [IDX_W-1:0]    idx_r;
  logic [IDX_W-1:0]    idx_n_s;
  logic                wts_valid_r;
  logic                wts_valid_n_s;
  logic                in_ready_r;
  logic                out_valid_r;
  logic [N_IN*DW-1:0]  x_vec_r;
  logic [N_IN*DW-1:0]  w_vec_r;
  logic [DW-1:0]       bias_r;
  logic                accept_s;
  logic                last_idx_s;

  // A byte is taken only on a handshake; a byte offered with flush is dropped.
  assign accept_s   = in_valid & in_ready_r & ~flush;
  assign last_idx_s = (idx_r == IDX_LAST);

  assign in_ready  = in_ready_r;
  assign out_valid = out_valid_r;
  assign x_vec     = x_vec_r;
  assign w_vec     = w_vec_r;
  assign bias      = bias_r;

  // Next-state, index and weight-valid logic.
  always_comb begin
    state_n_s     = state_r;
    idx_n_s       = idx_r;
    wts_valid_n_s = wts_valid_r;
    if (flush) begin
      state_n_s     = LOAD_X;
      idx_n_s       = IDX_ZERO;
      wts_valid_n_s = 1'b0;
    end else begin
      case (state_r)
        LOAD_X: begin
          if (accept_s) begin
            if (last_idx_s) begin
              idx_n_s = IDX_ZERO;
              // Weight reuse only makes sense once a full set has been loaded.
              if (x_only && wts_valid_r) begin
                state_n_s = HOLD;
              end else begin
                state_n_s = LOAD_W;
              end
            end else begin
              idx_n_s = idx_r + IDX_ONE;
            end
          end else begin
            idx_n_s = idx_r;
          end
        end
        LOAD_W: begin
          if (accept_s) begin
            if (last_idx_s) begin
              idx_n_s   = IDX_ZERO;
              state_n_s = LOAD_B;
            end else begin
              idx_n_s = idx_r + IDX_ONE;
            end
          end else begin
            idx_n_s = idx_r;
          end
        end
        LOAD_B: begin
          if (accept_s) begin
            state_n_s     = HOLD;
            wts_valid_n_s = 1'b1;
          end else begin
            state_n_s = LOAD_B;
          end
        end
        HOLD: begin
          // out_valid is always 1 in HOLD, so out_ready alone completes it.
          if (out_ready) begin
            state_n_s = LOAD_X;
            idx_n_s   = IDX_ZERO;
          end else begin
            state_n_s = HOLD;
          end
        end
        default: begin
          state_n_s     = LOAD_X;
          idx_n_s       = IDX_ZERO;
          wts_valid_n_s = 1'b0;
        end
      endcase
    end
  end

  // State, index and handshake registers; both handshakes follow the next state.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_r     <= LOAD_X;
      idx_r       <= IDX_ZERO;
      wts_valid_r <= 1'b0;
      in_ready_r  <= 1'b0;
      out_valid_r <= 1'b0;
    end else begin
      state_r     <= state_n_s;
      idx_r       <= idx_n_s;
      wts_valid_r <= wts_valid_n_s;
      in_ready_r  <= (state_n_s != HOLD);
      out_valid_r <= (state_n_s == HOLD);
    end
  end

  // Operand registers: write the accepted byte into the lane picked by state and index.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      x_vec_r <= '0;
      w_vec_r <= '0;
      bias_r  <= '0;
    end else if (accept_s) begin
      case (state_r)
        LOAD_X:  x_vec_r[int'(idx_r)*DW +: DW] <= in_data;
        LOAD_W:  w_vec_r[int'(idx_r)*DW +: DW] <= in_data;
        LOAD_B:  bias_r <= in_data;
        default: bias_r <= bias_r;
      endcase
    end
  end

endmodule : neuron_operand_loader

// File: tb/tb_neuron_operand_loader.sv
// Self-checking bench for neuron_operand_loader: a reference model tracks the
// frame contents, pushes the expected operand set when a frame completes, and
// a negedge monitor pops and compares whenever out_valid presents a set.
module tb_neuron_operand_loader;

  localparam int N  = 8;
  localparam int DW = 8;
  localparam int VW = N * DW;
  localparam int EW = 2 * VW + DW;

  logic          clk = 1'b0;
  logic          rst_n = 1'b0;
  logic [DW-1:0] in_data = '0;
  logic          in_valid = 1'b0;
  logic          in_ready;
  logic          x_only = 1'b0;
  logic          flush = 1'b0;
  logic [VW-1:0] x_vec;
  logic [VW-1:0] w_vec;
  logic [DW-1:0] bias;
  logic          out_valid;
  logic          out_ready = 1'b0;

  int checks = 0;
  int errors = 0;

  // reference model state
  logic [DW-1:0] mx [N];
  logic [DW-1:0] mw [N];
  logic [DW-1:0] mb;
  int            m_pos;   // bytes of the current frame taken so far
  bit            m_wv;    // a full weight/bias set is stored
  bit            m_hold;  // a completed set waits for the consumer
  logic [EW-1:0] exp_q [$];
  logic [EW-1:0] cur_exp;
  bit            prev_ov = 1'b0;

  neuron_operand_loader #(.N_IN(N), .DW(DW)) dut (
    .clk(clk), .rst_n(rst_n), .in_data(in_data), .in_valid(in_valid),
    .in_ready(in_ready), .x_only(x_only), .flush(flush), .x_vec(x_vec),
    .w_vec(w_vec), .bias(bias), .out_valid(out_valid), .out_ready(out_ready)
  );

  always #5 clk = ~clk;

  task automatic check(input string name, input logic [EW-1:0] act, input logic [EW-1:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s actual=%0h required=%0h t=%0t", name, act, exp, $time);
    end
  endtask

  function automatic logic [EW-1:0] model_set();
    logic [EW-1:0] v;
    v = '0;
    for (int i = 0; i < N; i++) begin
      v[i*DW +: DW]      = mx[i];
      v[VW + i*DW +: DW] = mw[i];
    end
    v[2*VW +: DW] = mb;
    return v;
  endfunction

  task automatic model_clear();
    for (int i = 0; i < N; i++) begin
      mx[i] = '0;
      mw[i] = '0;
    end
    mb = '0;
    m_pos = 0;
    m_wv = 1'b0;
    m_hold = 1'b0;
  endtask

  // Frame rules: N x bytes, then N w bytes and a bias unless the frame
  // reuses valid weights (x_only seen with the last x byte).
  task automatic model_accept(input logic [DW-1:0] d, input logic xo);
    if (m_pos < N) begin
      mx[m_pos] = d;
      if (m_pos == N - 1 && xo && m_wv) begin
        m_pos = 0;
        m_hold = 1'b1;
        exp_q.push_back(model_set());
      end else begin
        m_pos++;
      end
    end else if (m_pos < 2 * N) begin
      mw[m_pos - N] = d;
      m_pos++;
    end else begin
      mb = d;
      m_wv = 1'b1;
      m_pos = 0;
      m_hold = 1'b1;
      exp_q.push_back(model_set());
    end
  endtask

  // Monitor: compare each presented set, and its stability while held.
  always @(negedge clk) begin
    if (!rst_n) begin
      prev_ov = 1'b0;
    end else begin
      if (out_valid && !prev_ov) begin
        if (exp_q.size() == 0) begin
          checks++;
          errors++;
          $display("FAIL unexpected_out_valid actual=1 required=0 t=%0t", $time);
        end else begin
          cur_exp = exp_q.pop_front();
          check("frame_operands", {bias, w_vec, x_vec}, cur_exp);
        end
      end else if (out_valid && prev_ov) begin
        check("hold_stable", {bias, w_vec, x_vec}, cur_exp);
      end
      prev_ov = out_valid;
    end
  end

  // Offer one byte after 'gap' idle cycles; called at posedge+1.
  task automatic send_byte(input logic [DW-1:0] d, input logic xo, input int gap);
    repeat (gap) begin
      @(posedge clk);
      #1;
    end
    in_data = d;
    x_only = xo;
    in_valid = 1'b1;
    check("in_ready_loading", EW'(in_ready), EW'(1'b1));
    @(posedge clk);
    #1;
    in_valid = 1'b0;
    x_only = 1'b0;
    model_accept(d, xo);
    if (m_hold) begin
      check("out_valid_latency", EW'(out_valid), EW'(1'b1));
      check("in_ready_hold", EW'(in_ready), EW'(1'b0));
    end else begin
      check("out_valid_low_loading", EW'(out_valid), EW'(1'b0));
    end
  endtask

  // Random bytes until the frame completes or stop_after bytes are sent.
  task automatic send_random_frame(input logic xo, input int maxgap, input int stop_after);
    int n;
    n = 0;
    while (!m_hold && n != stop_after) begin
      send_byte(DW'($urandom), (m_pos == N - 1) ? xo : 1'b0, int'($urandom_range(0, maxgap)));
      n++;
    end
  endtask

  // Hold off the consumer for n cycles, then take the set.
  task automatic consume(input int n);
    out_ready = 1'b0;
    repeat (n) begin
      @(posedge clk);
      #1;
      check("bp_out_valid", EW'(out_valid), EW'(1'b1));
      check("bp_in_ready", EW'(in_ready), EW'(1'b0));
    end
    out_ready = 1'b1;
    @(posedge clk);
    #1;
    out_ready = 1'b0;
    m_hold = 1'b0;
    check("release_in_ready", EW'(in_ready), EW'(1'b1));
    check("release_out_valid", EW'(out_valid), EW'(1'b0));
  endtask

  // Flush with a byte offered in the same cycle; that byte must be dropped.
  task automatic do_flush(input logic [DW-1:0] d);
    in_data = d;
    in_valid = 1'b1;
    flush = 1'b1;
    @(posedge clk);
    #1;
    flush = 1'b0;
    in_valid = 1'b0;
    m_pos = 0;
    m_wv = 1'b0;
    m_hold = 1'b0;
    check("flush_out_valid", EW'(out_valid), EW'(1'b0));
    check("flush_in_ready", EW'(in_ready), EW'(1'b1));
  endtask

  // Reset pulse placed between clock edges.
  task automatic async_reset();
    #3;
    rst_n = 1'b0;
    #1;
    check("rst_outputs_zero", {bias, w_vec, x_vec}, '0);
    check("rst_out_valid", EW'(out_valid), EW'(1'b0));
    check("rst_in_ready", EW'(in_ready), EW'(1'b0));
    model_clear();
    exp_q.delete();
    @(posedge clk);
    #2;
    rst_n = 1'b1;
    @(posedge clk);
    #1;
    check("rst_release_in_ready", EW'(in_ready), EW'(1'b1));
  endtask

  initial begin
    logic [VW-1:0] x10;
    int r;
    model_clear();

    // reset state
    #12;
    check("reset_vectors", {bias, w_vec, x_vec}, '0);
    check("reset_out_valid", EW'(out_valid), EW'(1'b0));
    check("reset_in_ready", EW'(in_ready), EW'(1'b0));
    rst_n = 1'b1;
    @(posedge clk);
    #1;
    check("first_edge_in_ready", EW'(in_ready), EW'(1'b1));

    // full frame, x_only set right after reset must not shorten it
    for (int i = 0; i < N; i++) send_byte(DW'(i + 1), (i == N - 1), 0);
    for (int i = 0; i < N; i++) send_byte(DW'(8'hFF - i), 1'b0, 0);
    send_byte(8'h05, 1'b0, 0);
    check("x1_value", EW'(x_vec[7:0]), EW'(8'h01));
    check("w1_value", EW'(w_vec[7:0]), EW'(8'hFF));
    check("bias_value", EW'(bias), EW'(8'h05));
    consume(10);

    // x_only reuse
    for (int i = 0; i < N; i++) send_byte(8'h10, (i == N - 1), 0);
    x10 = {N{8'h10}};
    check("xonly_x_vec", EW'(x_vec), EW'(x10));
    check("xonly_w1_kept", EW'(w_vec[7:0]), EW'(8'hFF));
    check("xonly_bias_kept", EW'(bias), EW'(8'h05));
    consume(1);

    // flush after 11 accepts; weight reuse must then be refused
    send_random_frame(1'b0, 0, 11);
    do_flush(8'hAA);
    send_random_frame(1'b1, 0, -1);
    consume(0);

    // asynchronous reset mid-frame, then a frame with every-other-cycle gaps
    send_random_frame(1'b0, 0, 5);
    async_reset();
    for (int i = 0; i < 2 * N + 1; i++) send_byte(DW'($urandom), 1'b0, 1);
    consume(3);

    // randomised traffic
    for (int f = 0; f < 40; f++) begin
      r = int'($urandom_range(0, 9));
      if (r == 0) begin
        send_random_frame(1'b0, 2, int'($urandom_range(1, 2 * N)));
        do_flush(DW'($urandom));
      end else begin
        send_random_frame(1'($urandom_range(0, 1)), 2, -1);
        if (r == 1) do_flush(DW'($urandom));
        else consume(int'($urandom_range(0, 4)));
      end
    end

    repeat (3) @(posedge clk);
    #1;
    check("scoreboard_drained", EW'(exp_q.size()), EW'(0));
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule : tb_neuron_operand_loader
